// File: rtl/bin2bcd_pkg.sv
// rtl/bin2bcd_pkg.sv - shared constants, state enum and blank-mask helper for bin2bcd_seq
package bin2bcd_pkg;

  localparam int WIDTH   = 20;
  localparam int NDIGITS = 6;
  localparam int CNT_W   = $clog2(WIDTH);

  localparam logic [WIDTH-1:0]     MAX_DEC     = WIDTH'(999_999);
  localparam logic [4*NDIGITS-1:0] OVF_PATTERN = 24'h999999;
  localparam logic [CNT_W-1:0]     CNT_LAST    = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    WAIT_LOW
  } state_e;

  // Bit i set when digit i and every digit above it are zero; units always shown.
  function automatic logic [NDIGITS-1:0] blank_mask(input logic [4*NDIGITS-1:0] bcd);
    logic [NDIGITS-1:0] m;
    logic               all_zero;
    m        = '0;
    all_zero = 1'b1;
    for (int i = NDIGITS - 1; i >= 1; i--) begin
      all_zero = all_zero && (bcd[4*i +: 4] == 4'd0);
      m[i]     = all_zero;
    end
    return m;
  endfunction

endpackage

// File: rtl/bin2bcd_if.sv
// rtl/bin2bcd_if.sv - request/result bundle between upstream history buffer and bin2bcd_seq
interface bin2bcd_if;
  import bin2bcd_pkg::*;

  logic                   valid_i;
  logic [WIDTH-1:0]       bin_i;
  logic                   rdy_o;
  logic                   busy_o;
  logic [4*NDIGITS-1:0]   bcd_o;
  logic                   ovf_o;
  logic [NDIGITS-1:0]     blank_o;

  modport master (
    output valid_i, bin_i,
    input  rdy_o, busy_o, bcd_o, ovf_o, blank_o
  );

  modport slave (
    input  valid_i, bin_i,
    output rdy_o, busy_o, bcd_o, ovf_o, blank_o
  );

endinterface

// File: rtl/bcd_add3_digit.sv
// rtl/bcd_add3_digit.sv - double-dabble correction for one BCD digit (+3 when >= 5)
module bcd_add3_digit (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - one-bit-per-cycle double-dabble binary to packed BCD converter
// Optional leading-zero blanking enabled by defining BIN2BCD_BLANK_EN.
module bin2bcd_seq
  import bin2bcd_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      en,
  bin2bcd_if.slave  bus
);

  localparam int SW = 4 * NDIGITS;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     shift_q, shift_d;
  logic [SW-1:0]        scratch_q, scratch_d;
  logic                 ovf_flag_q, ovf_flag_d;
  logic                 rdy_q, rdy_d;
  logic                 busy_q, busy_d;
  logic [SW-1:0]        bcd_q, bcd_d;
  logic                 ovf_q, ovf_d;

  logic [SW-1:0]        corr;
  logic [SW-1:0]        scratch_sh;
  logic [WIDTH-1:0]     shift_sh;

  for (genvar g = 0; g < NDIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .din  (scratch_q[4*g +: 4]),
      .dout (corr[4*g +: 4])
    );
  end

  assign scratch_sh = {corr[SW-2:0], shift_q[WIDTH-1]};
  assign shift_sh   = {shift_q[WIDTH-2:0], 1'b0};

`ifdef BIN2BCD_BLANK_EN
  localparam logic [NDIGITS-1:0] BLANK_RST = {{(NDIGITS-1){1'b1}}, 1'b0};
  logic [NDIGITS-1:0] blank_q, blank_d;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    ovf_flag_d = ovf_flag_q;
    rdy_d      = rdy_q;
    busy_d     = busy_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
`ifdef BIN2BCD_BLANK_EN
    blank_d    = blank_q;
`endif
    if (en) begin
      case (state_q)
        IDLE: begin
          if (bus.valid_i) begin
            shift_d    = bus.bin_i;
            scratch_d  = '0;
            cnt_d      = '0;
            ovf_flag_d = (bus.bin_i > MAX_DEC);
            busy_d     = 1'b1;
            state_d    = SHIFT;
          end
        end
        SHIFT: begin
          scratch_d  = scratch_sh;
          shift_d    = shift_sh;
          cnt_d      = cnt_q + 1'b1;
          // A carry out of the top digit can only come from an out-of-range input.
          ovf_flag_d = ovf_flag_q | corr[SW-1];
          if (cnt_q == CNT_LAST) begin
            bcd_d   = ovf_flag_d ? OVF_PATTERN : scratch_sh;
            ovf_d   = ovf_flag_d;
`ifdef BIN2BCD_BLANK_EN
            blank_d = ovf_flag_d ? '0 : blank_mask(scratch_sh);
`endif
            rdy_d   = 1'b1;
            state_d = WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          rdy_d = 1'b0;
          if (!bus.valid_i) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      scratch_q  <= '0;
      ovf_flag_q <= 1'b0;
      rdy_q      <= 1'b0;
      busy_q     <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
`ifdef BIN2BCD_BLANK_EN
      blank_q    <= BLANK_RST;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      ovf_flag_q <= ovf_flag_d;
      rdy_q      <= rdy_d;
      busy_q     <= busy_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
`ifdef BIN2BCD_BLANK_EN
      blank_q    <= blank_d;
`endif
    end
  end

  assign bus.rdy_o  = rdy_q;
  assign bus.busy_o = busy_q;
  assign bus.bcd_o  = bcd_q;
  assign bus.ovf_o  = ovf_q;
`ifdef BIN2BCD_BLANK_EN
  assign bus.blank_o = blank_q;
`else
  assign bus.blank_o = '0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - directed and random checks of bin2bcd_seq against a decimal model
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;

  int n_checks = 0;
  int n_fails  = 0;

  bin2bcd_if bus();

  bin2bcd_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] ref_bcd(input int v);
    logic [23:0] r;
    int p;
    if (v > 999999) return 24'h999999;
    r = '0;
    p = 1;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [5:0] ref_blank(input int v);
    logic [5:0] m;
    int p;
    m = '0;
`ifdef BIN2BCD_BLANK_EN
    if (v <= 999999) begin
      p = 10;
      for (int i = 1; i < 6; i++) begin
        m[i] = (v < p);
        p = p * 10;
      end
    end
`else
    p = v;
`endif
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy"},   32'(bus.rdy_o),   32'd0);
    check({tag, "_busy"},  32'(bus.busy_o),  32'd0);
    check({tag, "_bcd"},   32'(bus.bcd_o),   32'd0);
    check({tag, "_ovf"},   32'(bus.ovf_o),   32'd0);
`ifdef BIN2BCD_BLANK_EN
    check({tag, "_blank"}, 32'(bus.blank_o), 32'h3e);
`else
    check({tag, "_blank"}, 32'(bus.blank_o), 32'h00);
`endif
  endtask

  // Issue one request and check latency, result, pulse width and busy release.
  task automatic do_req(input int v, input int hold, input int en_gap);
    int lat;
    @(negedge clk);
    bus.valid_i = 1'b1;
    bus.bin_i   = 20'(v);
    @(posedge clk);
    @(negedge clk);
    check("busy_after_capture", 32'(bus.busy_o), 32'd1);
    bus.bin_i = 20'(v ^ 20'h5a5a5);
    lat = 0;
    while (lat < 100) begin
      if (en_gap > 0 && lat == 5) en = 1'b0;
      if (en_gap > 0 && lat == 5 + en_gap) en = 1'b1;
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.rdy_o) break;
    end
    en = 1'b1;
    check("latency", 32'(lat), 32'(20 + en_gap));
    check("bcd",     32'(bus.bcd_o),   32'(ref_bcd(v)));
    check("ovf",     32'(bus.ovf_o),   32'(v > 999999));
    check("blank",   32'(bus.blank_o), 32'(ref_blank(v)));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_rdy",  32'(bus.rdy_o),  32'd0);
      check("hold_busy", 32'(bus.busy_o), 32'd1);
    end
    bus.valid_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("release_busy", 32'(bus.busy_o), 32'd0);
    check("release_rdy",  32'(bus.rdy_o),  32'd0);
    check("bcd_hold",     32'(bus.bcd_o),  32'(ref_bcd(v)));
  endtask

  initial begin
    int lat;
    int saw_rdy;
    bus.valid_i = 1'b0;
    bus.bin_i   = '0;

    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_reset");

    do_req(0, 0, 0);
    do_req(865535, 0, 0);
    do_req(1000000, 0, 0);
    do_req(42, 5, 0);

    // Asynchronous reset in the middle of converting 123456.
    @(negedge clk);
    bus.valid_i = 1'b1;
    bus.bin_i   = 20'd123456;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    bus.valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    saw_rdy = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (bus.rdy_o) saw_rdy++;
    end
    check("no_rdy_after_abort", 32'(saw_rdy), 32'd0);
    do_req(123456, 0, 0);

    do_req(300001, 0, 7);

    for (int r = 0; r < 10; r++) begin
      do_req(int'($urandom_range(0, 1048575)), int'($urandom_range(0, 3)), 0);
    end
    do_req(999999, 1, 0);
    do_req(1048575, 0, 0);

    lat = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
